topk_sort: RTL

Parametrised top-K selector for the PageRank ranking stage. It captures a flat vector of NUM_WORDS scores on `start` and performs a partial selection sort over TOP_K passes. It then presents the K largest scores, each with its original index (ID), ordered from the largest score down. This generalises the fixed top-10 sorter: K, word count and ID width are parameters, there is an explicit start/busy/done handshake and a deterministic tie-break, and re-sorting needs no reset.

---
 rtl/topk_sort_if.sv | 20 ++
 rtl/topk_sort.sv | 130 +++++++++++++
 2 files changed

// File: rtl/topk_sort_if.sv
// topk_sort_if: start/busy/done handshake and flat data buses of the top-K selector.
// master = requester (drives start/array_in), slave = the sorter.
interface topk_sort_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WORDS  = 16,
    parameter int TOP_K      = 10,
    parameter int ID_WIDTH   = 6
) ();
    logic                          start;
    logic [DATA_WIDTH*NUM_WORDS-1:0] array_in;
    logic [DATA_WIDTH*TOP_K-1:0]   array_out;
    logic [ID_WIDTH*TOP_K-1:0]     id_out;
    logic                          busy;
    logic                          done;

    modport master (output start, output array_in,
                    input array_out, input id_out, input busy, input done);
    modport slave  (input start, input array_in,
                    output array_out, output id_out, output busy, output done);
endinterface

// File: rtl/topk_sort.sv
// topk_sort: captures NUM_WORDS scores on start and runs TOP_K passes of a
// partial selection sort (one compare per SCAN cycle, one SWAP per pass).
// Results sit in val/id slots 0..TOP_K-1; ties favour the lower original index.
// Optional macro TOPK_ASCEND_EN: select the TOP_K smallest scores instead.
module topk_sort #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_WORDS  = 16,
    parameter int TOP_K      = 10,
    parameter int ID_WIDTH   = 6
) (
    input  logic        clk,
    input  logic        rst,
    topk_sort_if.slave  bus
);
    localparam int PW = $clog2(NUM_WORDS);
    localparam logic [PW-1:0] LAST  = PW'(NUM_WORDS - 1);
    localparam logic [PW-1:0] KLAST = PW'(TOP_K - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SWAP, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] val_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] val_d [NUM_WORDS];
    logic [ID_WIDTH-1:0]   id_q  [NUM_WORDS];
    logic [ID_WIDTH-1:0]   id_d  [NUM_WORDS];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         p_q, p_d;
    logic [PW-1:0]         max_q, max_d;
    logic                  busy_q, done_q;

    // True when entry a ranks ahead of entry b: value first, then lower id.
    function automatic logic key_gt(input logic [DATA_WIDTH-1:0] va,
                                    input logic [ID_WIDTH-1:0]   ia,
                                    input logic [DATA_WIDTH-1:0] vb,
                                    input logic [ID_WIDTH-1:0]   ib);
`ifdef TOPK_ASCEND_EN
        return (va < vb) || ((va == vb) && (ia < ib));
`else
        return (va > vb) || ((va == vb) && (ia < ib));
`endif
    endfunction

    // Next-state, pointer and storage update for capture, scan and swap.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        p_d     = p_q;
        max_d   = max_q;
        for (int j = 0; j < NUM_WORDS; j++) begin
            val_d[j] = val_q[j];
            id_d[j]  = id_q[j];
        end
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    for (int j = 0; j < NUM_WORDS; j++) begin
                        val_d[j] = bus.array_in[j*DATA_WIDTH +: DATA_WIDTH];
                        id_d[j]  = ID_WIDTH'(j);
                    end
                    head_d  = '0;
                    max_d   = LAST;
                    p_d     = LAST - 1'b1;
                    state_d = (head_d == LAST) ? SWAP : SCAN;
                end
            end
            SCAN: begin
                if (key_gt(val_q[p_q], id_q[p_q], val_q[max_q], id_q[max_q]))
                    max_d = p_q;
                if (p_q == head_q)
                    state_d = SWAP;
                else
                    p_d = p_q - 1'b1;
            end
            SWAP: begin
                // Writing max last keeps a self-swap harmless.
                val_d[head_q] = val_q[max_q];
                id_d[head_q]  = id_q[max_q];
                val_d[max_q]  = val_q[head_q];
                id_d[max_q]   = id_q[head_q];
                if (head_q == KLAST) begin
                    state_d = DONE;
                end else begin
                    head_d  = head_q + 1'b1;
                    max_d   = LAST;
                    p_d     = LAST - 1'b1;
                    state_d = (head_d == LAST) ? SWAP : SCAN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register state, storage and the registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            p_q     <= '0;
            max_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int j = 0; j < NUM_WORDS; j++) begin
                val_q[j] <= '0;
                id_q[j]  <= ID_WIDTH'(j);
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            p_q     <= p_d;
            max_q   <= max_d;
            busy_q  <= (state_d == SCAN) || (state_d == SWAP);
            done_q  <= (state_d == DONE);
            for (int j = 0; j < NUM_WORDS; j++) begin
                val_q[j] <= val_d[j];
                id_q[j]  <= id_d[j];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TOP_K; gi++) begin : g_out
            assign bus.array_out[gi*DATA_WIDTH +: DATA_WIDTH] = val_q[gi];
            assign bus.id_out[gi*ID_WIDTH +: ID_WIDTH]         = id_q[gi];
        end
    endgenerate

    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
